fight_round_ctrl: RTL

- Match sequencer and hit arbiter for the two-player fighter.
- Drives the `start` enable of both player movement blocks and sequences IDLE -> countdown -> fight -> KO.
- Samples both players' attack/block flags against the shared `collision` signal and arbitrates damage into two health counters.
- Runs the round timer and declares the winner.

---
 rtl/fight_round_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/fight_round_ctrl.sv
// Match sequencer and hit arbiter for the two-player fighter: runs countdown,
// fight and KO phases, resolves landed hits into health and declares a winner.
module fight_round_ctrl #(
  parameter int MAX_HEALTH      = 100,
  parameter int DMG_KICK        = 10,
  parameter int DMG_PUNCH       = 5,
  parameter int DMG_CPUNCH      = 8,
  parameter int COOLDOWN_FRAMES = 20,
  parameter int READY_FRAMES    = 120,
  parameter int FRAMES_PER_SEC  = 60,
  parameter int FIGHT_SECONDS   = 99,
  parameter int END_FRAMES      = 180
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       collision,
  input  logic       kick1,
  input  logic       punch1,
  input  logic       crouchpunch1,
  input  logic       block1,
  input  logic       kick2,
  input  logic       punch2,
  input  logic       crouchpunch2,
  input  logic       block2,
  output logic       start,
  output logic [6:0] health1,
  output logic [6:0] health2,
  output logic [6:0] round_secs,
  output logic [1:0] winner,
  output logic       hit1,
  output logic       hit2,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_COUNTDOWN = 2'b01,
    S_FIGHT     = 2'b10,
    S_KO        = 2'b11
  } state_e;

  // One frame counter serves the countdown, the per-second timer and the KO hold.
  localparam int CNT_MAX = (READY_FRAMES > END_FRAMES) ?
                           ((READY_FRAMES > FRAMES_PER_SEC) ? READY_FRAMES : FRAMES_PER_SEC) :
                           ((END_FRAMES > FRAMES_PER_SEC) ? END_FRAMES : FRAMES_PER_SEC);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int CD_W  = $clog2(COOLDOWN_FRAMES + 1);

  localparam logic [CNT_W-1:0] READY_LAST = CNT_W'(READY_FRAMES - 1);
  localparam logic [CNT_W-1:0] SEC_LAST   = CNT_W'(FRAMES_PER_SEC - 1);
  localparam logic [CNT_W-1:0] END_LAST   = CNT_W'(END_FRAMES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CD_W-1:0]   cd1_q, cd2_q;
  logic              fight_tick, land1, land2, sec_wrap, start_d;
  logic [6:0]        dmg_to1, dmg_to2, health1_nxt, health2_nxt, secs_nxt;
  logic [1:0]        ko_winner;

  function automatic logic [6:0] attack_dmg(input logic kick, input logic cpunch,
                                            input logic punch, input logic def_block);
    logic [6:0] base;
    base = 7'd0;
    if (kick)        base = 7'(DMG_KICK);
    else if (cpunch) base = 7'(DMG_CPUNCH);
    else if (punch)  base = 7'(DMG_PUNCH);
    return def_block ? (base >> 1) : base;
  endfunction

  function automatic logic [6:0] sat_sub(input logic [6:0] h, input logic [6:0] d);
    return (d >= h) ? 7'd0 : (h - d);
  endfunction

  // Hit arbitration: both players are resolved from the same pre-tick health.
  always_comb begin
    fight_tick  = frame_tick && (state_q == S_FIGHT);
    land1       = fight_tick && collision && (cd1_q == '0) && (kick1 || crouchpunch1 || punch1);
    land2       = fight_tick && collision && (cd2_q == '0) && (kick2 || crouchpunch2 || punch2);
    dmg_to2     = land1 ? attack_dmg(kick1, crouchpunch1, punch1, block2) : 7'd0;
    dmg_to1     = land2 ? attack_dmg(kick2, crouchpunch2, punch2, block1) : 7'd0;
    health1_nxt = sat_sub(health1, dmg_to1);
    health2_nxt = sat_sub(health2, dmg_to2);
    sec_wrap    = (cnt_q == SEC_LAST);
    secs_nxt    = sec_wrap ? (round_secs - 7'd1) : round_secs;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    if (frame_tick) begin
      unique case (state_q)
        S_IDLE:      if (start_btn) state_d = S_COUNTDOWN;
        S_COUNTDOWN: if (cnt_q == READY_LAST) state_d = S_FIGHT;
        S_FIGHT:     if (health1_nxt == 7'd0 || health2_nxt == 7'd0 || secs_nxt == 7'd0)
                       state_d = S_KO;
        S_KO:        if (cnt_q == END_LAST) state_d = S_IDLE;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    start_d = (state_q == S_FIGHT);
    if (health1_nxt == 7'd0 && health2_nxt == 7'd0) ko_winner = 2'b11;
    else if (health1_nxt == 7'd0)                   ko_winner = 2'b10;
    else if (health2_nxt == 7'd0)                   ko_winner = 2'b01;
    else if (health1_nxt > health2_nxt)             ko_winner = 2'b01;
    else if (health2_nxt > health1_nxt)             ko_winner = 2'b10;
    else                                            ko_winner = 2'b11;
  end

  assign state = state_q;

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      start      <= 1'b0;
      hit1       <= 1'b0;
      hit2       <= 1'b0;
      health1    <= 7'(MAX_HEALTH);
      health2    <= 7'(MAX_HEALTH);
      round_secs <= 7'(FIGHT_SECONDS);
      winner     <= 2'b00;
      cnt_q      <= '0;
      cd1_q      <= '0;
      cd2_q      <= '0;
    end else begin
      start <= start_d;
      hit1  <= land1;
      hit2  <= land2;
      if (frame_tick) begin
        unique case (state_q)
          S_IDLE: if (start_btn) begin
            health1    <= 7'(MAX_HEALTH);
            health2    <= 7'(MAX_HEALTH);
            round_secs <= 7'(FIGHT_SECONDS);
            winner     <= 2'b00;
            cnt_q      <= '0;
            cd1_q      <= '0;
            cd2_q      <= '0;
          end
          S_COUNTDOWN: cnt_q <= (cnt_q == READY_LAST) ? '0 : cnt_q + CNT_W'(1);
          S_FIGHT: begin
            health1    <= health1_nxt;
            health2    <= health2_nxt;
            round_secs <= secs_nxt;
            if (land1)              cd1_q <= CD_W'(COOLDOWN_FRAMES);
            else if (cd1_q != '0)   cd1_q <= cd1_q - CD_W'(1);
            if (land2)              cd2_q <= CD_W'(COOLDOWN_FRAMES);
            else if (cd2_q != '0)   cd2_q <= cd2_q - CD_W'(1);
            if (state_d == S_KO) begin
              winner <= ko_winner;
              cnt_q  <= '0;
            end else begin
              cnt_q  <= sec_wrap ? '0 : cnt_q + CNT_W'(1);
            end
          end
          S_KO:    cnt_q <= (cnt_q == END_LAST) ? '0 : cnt_q + CNT_W'(1);
          default: cnt_q <= '0;
        endcase
      end
    end
  end

endmodule
